rgb_burst_packer: RTL and testbench
===================================

// Module: rgb_burst_packer
// PURPOSE
//  Downstream consumer of the Left/Down FIFO read controller. Collects the pixels of one RGB burst
//  (valid_RGB_data strobes, framed by flag_RGB_data) into an internal FIFO. After the burst closes,
//  it emits a framed byte packet (header, line index, length, R/G/B bytes, XOR checksum) on a
//  valid/ready byte stream toward the UART/Ethernet transmit stage.
// PARAMETERS
//  MAX_PIX    123    max pixels per burst; burst force-closed when reached
//  FIFO_AW    7      pixel FIFO address width (depth 2**FIFO_AW, must be >= MAX_PIX)
//  HDR0       8'h55  first header byte
//  HDR1       8'hAA  second header byte
// PORTS
//  clk_200MHz       in   1   single clock; all logic on posedge
//  reset            in   1   synchronous, active-high reset
//  RGB_data         in   24  pixel {R[23:16],G[15:8],B[7:0]}, sampled when valid_RGB_data=1
//  valid_RGB_data   in   1   one-cycle pixel strobe
//  flag_RGB_data    in   1   burst window, HDMI domain; 2-FF synchronised internally
//  vs               in   1   frame sync, HDMI domain; 2-FF synchronised internally
//  tx_data          out  8   packet byte
//  tx_valid         out  1   tx_data valid
//  tx_ready         in   1   sink accepts byte when tx_valid & tx_ready
//  busy             out  1   1 in any state except IDLE
//  drop_cnt         out  16  saturating count of pixels dropped (not collectable)
// BEHAVIOUR
//  Reset: tx_data=0, tx_valid=0, busy=0, drop_cnt=0, line_idx=0, FIFO empty, state=IDLE, csum=0.
//  Sync: flag_s/vs_s = 2nd flop of 2-FF chains; rise = flag_s & ~flag_s_d; fall = ~flag_s & flag_s_d.
//  vs_s rising edge: line_idx <= 0 (takes priority over the increment in the same cycle).
//  FSM: IDLE -> COLLECT on flag rise (pix_cnt<=0, FIFO flushed).
//   COLLECT: valid_RGB_data writes FIFO, pix_cnt++. Exit on flag fall or pix_cnt==MAX_PIX
//    after the write. pix_cnt==0 at exit -> IDLE, no packet, line_idx unchanged;
//    else -> HDR0 with len<=pix_cnt.
//   HDR0 -> HDR1 -> LINE_H -> LINE_L -> LEN -> PIX_R -> PIX_G -> PIX_B -> (PIX_R while
//    pixels remain, else CSUM) -> IDLE. Each state holds until its byte is accepted
//    (tx_valid & tx_ready).
//  Bytes: HDR0, HDR1, line_idx[15:8], line_idx[7:0], len[7:0], then per pixel R,G,B,
//   then csum = XOR of every byte from LINE_H through the last B (header excluded).
//  tx_valid=1 in HDR0..CSUM; tx_data and tx_valid are registered and stable until accepted
//   (AXI-stream rule: tx_valid never deasserts without a handshake).
//  FIFO pop at PIX_R entry (first-word-fall-through or a 1-cycle prefetch is allowed;
//   the byte order on the port is fixed).
//  line_idx increments by 1 (wraps 16'hFFFF->0) on CSUM acceptance.
//  Drops: valid_RGB_data outside COLLECT, or in COLLECT with pix_cnt==MAX_PIX,
//   -> drop_cnt++ (saturate at 16'hFFFF). A flag rise outside IDLE is ignored.
//  Simultaneous valid and flag fall in COLLECT: the pixel is written, then the burst closes.
//  Reset mid-packet: immediate return to the reset state; the partial packet is abandoned.
//  Latency: first header byte valid 1 cycle after the COLLECT exit decision.
//   With tx_ready=1: 6+3*len cycles per packet.
// STRUCTURE
//  Shared package rgb_pkt_pkg: state enum, HDR0/HDR1, MAX_PIX, pixel byte slice constants.
//  One sub-module: sync_fifo_24 (parameter AW; ports wr_en/din/rd_en/dout/empty/full/flush).
//  Top level holds the synchronisers, FSM, counters, and checksum.
// TESTING
//  1 Burst of 3 pixels 0x112233,0x445566,0x778899, tx_ready=1, line_idx=0 -> bytes
//    55 AA 00 00 03 11 22 33 44 55 66 77 88 99 CS, CS = XOR(00,00,03,11..99).
//  2 Burst of 130 valid strobes -> packet len=123 (0x7B), 369 pixel bytes, drop_cnt=7.
//  3 tx_ready toggled randomly -> same byte sequence as test 1; tx_data stable while tx_valid&~tx_ready.
//  4 flag pulse with no valid strobes -> no tx_valid; line_idx stays 0. Next 1-pixel burst -> line bytes 00 00.
//  5 Two 1-pixel bursts, then vs pulse, then a third burst -> line bytes 00 00, 00 01, then 00 00.
//  6 reset asserted at the PIX_G byte -> next cycle tx_valid=0, busy=0; a new burst yields a
//    clean packet with line_idx=0.

Source files
------------

// File: rtl/rgb_pkt_pkg.sv
// Shared constants and FSM state type for the RGB burst packer.
// Pixel layout is {R, G, B}, one byte per channel.
package rgb_pkt_pkg;

    localparam int unsigned PKT_MAX_PIX = 123;
    localparam logic [7:0]  PKT_HDR0    = 8'h55;
    localparam logic [7:0]  PKT_HDR1    = 8'hAA;

    localparam int unsigned R_LSB = 16;
    localparam int unsigned G_LSB = 8;
    localparam int unsigned B_LSB = 0;

    typedef enum logic [3:0] {
        StIdle,
        StCollect,
        StHdr0,
        StHdr1,
        StLineH,
        StLineL,
        StLen,
        StPixR,
        StPixG,
        StPixB,
        StCsum
    } state_e;

endpackage

// File: rtl/sync_fifo_24.sv
// Single-clock 24-bit FIFO with first-word-fall-through read and a synchronous flush.
// dout always shows the oldest entry while empty is low.
module sync_fifo_24 #(
    parameter int unsigned AW = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [23:0] din,
    input  logic        rd_en,
    output logic [23:0] dout,
    output logic        empty,
    output logic        full
);

    localparam int unsigned Depth = 2 ** AW;

    logic [23:0]   mem [Depth];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = count[AW];

endmodule

// File: rtl/rgb_burst_packer.sv
// Collects one framed RGB burst into a FIFO, then streams it out as a byte packet:
// HDR0 HDR1 line_hi line_lo len {R G B}* csum, with csum covering line_hi..last B.
module rgb_burst_packer
    import rgb_pkt_pkg::*;
#(
    parameter int unsigned MAX_PIX = PKT_MAX_PIX,
    parameter int unsigned FIFO_AW = 7,
    parameter logic [7:0]  HDR0    = PKT_HDR0,
    parameter logic [7:0]  HDR1    = PKT_HDR1
) (
    input  logic        clk_200MHz,
    input  logic        reset,
    input  logic [23:0] RGB_data,
    input  logic        valid_RGB_data,
    input  logic        flag_RGB_data,
    input  logic        vs,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] drop_cnt
);

    localparam logic [7:0] MaxCnt = 8'(MAX_PIX);

    state_e      state;
    logic        flag_m, flag_s, flag_s_d;
    logic        vs_m, vs_s, vs_s_d;
    logic [7:0]  pix_cnt;
    logic [7:0]  len;
    logic [7:0]  rem;
    logic [15:0] line_idx;
    logic [7:0]  csum;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;

    logic        flag_rise, flag_fall, vs_rise;
    logic        accept;
    logic        wr_en, rd_en, flush, drop;
    logic [7:0]  cnt_after;
    logic        burst_done;
    logic [23:0] fifo_dout;
    logic [7:0]  fifo_r;
    logic        fifo_empty, fifo_full;

    assign flag_rise = flag_s & ~flag_s_d;
    assign flag_fall = ~flag_s & flag_s_d;
    assign vs_rise   = vs_s & ~vs_s_d;
    assign accept    = tx_valid & tx_ready;

    assign wr_en      = valid_RGB_data && (state == StCollect) && (pix_cnt != MaxCnt) && !fifo_full;
    assign drop       = valid_RGB_data && !wr_en;
    assign cnt_after  = pix_cnt + {7'd0, wr_en};
    // A pixel arriving with the closing edge is kept; the cap is checked after the write.
    assign burst_done = flag_fall || (cnt_after == MaxCnt);
    assign flush      = (state == StIdle) && flag_rise;
    assign rd_en      = accept && !fifo_empty &&
                        ((state == StLen) || ((state == StPixB) && (rem != 8'd0)));
    assign fifo_r     = fifo_dout[R_LSB +: 8];
    assign busy       = (state != StIdle);

    sync_fifo_24 #(
        .AW(FIFO_AW)
    ) u_fifo (
        .clk   (clk_200MHz),
        .reset (reset),
        .flush (flush),
        .wr_en (wr_en),
        .din   (RGB_data),
        .rd_en (rd_en),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk_200MHz) begin
        if (reset) begin
            state    <= StIdle;
            flag_m   <= 1'b0;
            flag_s   <= 1'b0;
            flag_s_d <= 1'b0;
            vs_m     <= 1'b0;
            vs_s     <= 1'b0;
            vs_s_d   <= 1'b0;
            pix_cnt  <= '0;
            len      <= '0;
            rem      <= '0;
            line_idx <= '0;
            csum     <= '0;
            pix_g    <= '0;
            pix_b    <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            drop_cnt <= '0;
        end else begin
            flag_m   <= flag_RGB_data;
            flag_s   <= flag_m;
            flag_s_d <= flag_s;
            vs_m     <= vs;
            vs_s     <= vs_m;
            vs_s_d   <= vs_s;

            if (vs_rise) begin
                line_idx <= '0;
            end else if ((state == StCsum) && accept) begin
                line_idx <= line_idx + 16'd1;
            end

            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end

            // Bytes are folded into csum as they are loaded; a loaded byte is always sent.
            unique case (state)
                StIdle: begin
                    if (flag_rise) begin
                        state   <= StCollect;
                        pix_cnt <= '0;
                    end
                end
                StCollect: begin
                    pix_cnt <= cnt_after;
                    if (burst_done) begin
                        if (cnt_after == 8'd0) begin
                            state <= StIdle;
                        end else begin
                            state    <= StHdr0;
                            len      <= cnt_after;
                            rem      <= cnt_after;
                            csum     <= '0;
                            tx_valid <= 1'b1;
                            tx_data  <= HDR0;
                        end
                    end
                end
                StHdr0: begin
                    if (accept) begin
                        state   <= StHdr1;
                        tx_data <= HDR1;
                    end
                end
                StHdr1: begin
                    if (accept) begin
                        state   <= StLineH;
                        tx_data <= line_idx[15:8];
                        csum    <= csum ^ line_idx[15:8];
                    end
                end
                StLineH: begin
                    if (accept) begin
                        state   <= StLineL;
                        tx_data <= line_idx[7:0];
                        csum    <= csum ^ line_idx[7:0];
                    end
                end
                StLineL: begin
                    if (accept) begin
                        state   <= StLen;
                        tx_data <= len;
                        csum    <= csum ^ len;
                    end
                end
                StLen: begin
                    if (accept) begin
                        state   <= StPixR;
                        tx_data <= fifo_r;
                        csum    <= csum ^ fifo_r;
                        pix_g   <= fifo_dout[G_LSB +: 8];
                        pix_b   <= fifo_dout[B_LSB +: 8];
                        rem     <= rem - 8'd1;
                    end
                end
                StPixR: begin
                    if (accept) begin
                        state   <= StPixG;
                        tx_data <= pix_g;
                        csum    <= csum ^ pix_g;
                    end
                end
                StPixG: begin
                    if (accept) begin
                        state   <= StPixB;
                        tx_data <= pix_b;
                        csum    <= csum ^ pix_b;
                    end
                end
                StPixB: begin
                    if (accept) begin
                        if (rem != 8'd0) begin
                            state   <= StPixR;
                            tx_data <= fifo_r;
                            csum    <= csum ^ fifo_r;
                            pix_g   <= fifo_dout[G_LSB +: 8];
                            pix_b   <= fifo_dout[B_LSB +: 8];
                            rem     <= rem - 8'd1;
                        end else begin
                            state   <= StCsum;
                            tx_data <= csum;
                        end
                    end
                end
                StCsum: begin
                    if (accept) begin
                        state    <= StIdle;
                        tx_valid <= 1'b0;
                        tx_data  <= '0;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_burst_packer.sv
// Self-checking bench for rgb_burst_packer: bursts are turned into expected packets by a
// queue-based model and compared byte by byte with what the sink accepts.
module tb_rgb_burst_packer;

    localparam int MAXP = 123;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] rgb = '0;
    logic        valid = 1'b0;
    logic        flag = 1'b0;
    logic        vs = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic [15:0] drop_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    logic [23:0] pix_in[$];
    logic [15:0] model_line = '0;
    int          model_drops = 0;
    bit          rand_ready = 1'b0;
    bit          gaps = 1'b0;
    int          valid_cycles = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    rgb_burst_packer dut (
        .clk_200MHz     (clk),
        .reset          (reset),
        .RGB_data       (rgb),
        .valid_RGB_data (valid),
        .flag_RGB_data  (flag),
        .vs             (vs),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .busy           (busy),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sink: records accepted bytes and checks that a stalled byte is held.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall) begin
                check_eq("hold_valid", {31'd0, tx_valid}, 32'd1);
                check_eq("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
            end
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
            if (tx_valid) valid_cycles++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected packet from the burst contents, built directly from the framing rules.
    task automatic expect_burst(input int n);
        int         k;
        logic [7:0] body[$];
        logic [7:0] cs;
        k = (n > MAXP) ? MAXP : n;
        model_drops += n - k;
        exp_q.delete();
        if (k == 0) return;
        body.push_back(model_line[15:8]);
        body.push_back(model_line[7:0]);
        body.push_back(8'(k));
        for (int i = 0; i < k; i++) begin
            body.push_back(pix_in[i][23:16]);
            body.push_back(pix_in[i][15:8]);
            body.push_back(pix_in[i][7:0]);
        end
        cs = 8'h00;
        foreach (body[i]) cs ^= body[i];
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        foreach (body[i]) exp_q.push_back(body[i]);
        exp_q.push_back(cs);
        model_line++;
    endtask

    task automatic burst(input int n);
        rx_q.delete();
        valid_cycles = 0;
        expect_burst(n);
        flag = 1'b1;
        step(5);
        for (int i = 0; i < n; i++) begin
            valid = 1'b1;
            rgb   = pix_in[i];
            step(1);
            valid = 1'b0;
            if (gaps) step($urandom_range(0, 2));
        end
        flag = 1'b0;
        step(4);
    endtask

    task automatic finish_packet(input string tag, input int exp_valid_cycles);
        int t;
        for (t = 0; t < 3000 && busy; t++) step(1);
        check_eq({tag, "_done"}, {31'd0, busy}, 32'd0);
        step(2);
        check_eq({tag, "_size"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i),
                     (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
        end
        if (exp_valid_cycles >= 0)
            check_eq({tag, "_cycles"}, valid_cycles, exp_valid_cycles);
        check_eq({tag, "_drops"}, {16'd0, drop_cnt}, model_drops);
    endtask

    task automatic vs_pulse();
        vs = 1'b1;
        step(3);
        vs = 1'b0;
        step(4);
        model_line = '0;
    endtask

    task automatic load_t1();
        pix_in.delete();
        pix_in.push_back(24'h112233);
        pix_in.push_back(24'h445566);
        pix_in.push_back(24'h778899);
    endtask

    initial begin
        bit found;
        step(3);
        check_eq("rst_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_data", {24'd0, tx_data}, 32'd0);
        check_eq("rst_drops", {16'd0, drop_cnt}, 32'd0);
        reset = 1'b0;
        step(2);

        // Three known pixels, always-ready sink.
        load_t1();
        burst(3);
        finish_packet("t1", 15);
        check_eq("t1_len", {24'd0, rx_q[4]}, 32'h03);
        check_eq("t1_csum", {24'd0, rx_q[14]}, 32'h12);

        // Overlong burst is capped and the excess counted as drops.
        pix_in.delete();
        for (int i = 0; i < 130; i++) pix_in.push_back(24'($urandom));
        burst(130);
        finish_packet("t2", 6 + 3 * MAXP);
        check_eq("t2_len", {24'd0, rx_q[4]}, 32'h7B);
        check_eq("t2_drops7", {16'd0, drop_cnt}, 32'd7);

        // Back-pressure.
        rand_ready = 1'b1;
        load_t1();
        burst(3);
        finish_packet("t3", -1);
        rand_ready = 1'b0;

        // Empty burst produces nothing and does not advance the line.
        vs_pulse();
        pix_in.delete();
        burst(0);
        finish_packet("t4_empty", 0);
        pix_in.push_back(24'hA1B2C3);
        burst(1);
        finish_packet("t4_one", 9);
        check_eq("t4_line", {16'd0, rx_q[2], rx_q[3]}, 32'h0000);

        // Line index advances per packet and is cleared by vs.
        vs_pulse();
        burst(1);
        finish_packet("t5_a", 9);
        check_eq("t5_line_a", {16'd0, rx_q[2], rx_q[3]}, 32'h0000);
        burst(1);
        finish_packet("t5_b", 9);
        check_eq("t5_line_b", {16'd0, rx_q[2], rx_q[3]}, 32'h0001);
        vs_pulse();
        burst(1);
        finish_packet("t5_c", 9);
        check_eq("t5_line_c", {16'd0, rx_q[2], rx_q[3]}, 32'h0000);

        // Strobes while idle are dropped.
        repeat (2) begin
            valid = 1'b1;
            step(1);
            valid = 1'b0;
            step(1);
        end
        model_drops += 2;
        check_eq("idle_drops", {16'd0, drop_cnt}, model_drops);

        // Random bursts with gaps and random back-pressure.
        rand_ready = 1'b1;
        gaps = 1'b1;
        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(0, 12);
            pix_in.delete();
            for (int i = 0; i < n; i++) pix_in.push_back(24'($urandom));
            burst(n);
            finish_packet($sformatf("rnd%0d", r), -1);
        end
        rand_ready = 1'b0;
        gaps = 1'b0;

        // Reset while the G byte of the first pixel is on the port.
        load_t1();
        burst(3);
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(negedge clk);
            #1;
            if (tx_valid && tx_data == 8'h22 && rx_q.size() >= 6) found = 1'b1;
        end
        check_eq("t6_reach_pixg", {31'd0, found}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("t6_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("t6_busy", {31'd0, busy}, 32'd0);
        check_eq("t6_drops", {16'd0, drop_cnt}, 32'd0);
        step(2);
        model_line  = '0;
        model_drops = 0;
        rx_q.delete();
        burst(3);
        finish_packet("t6_after", 15);
        check_eq("t6_line", {16'd0, rx_q[2], rx_q[3]}, 32'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
